// File: rtl/serial_link_port_if.sv
// Bus interface between the MMU and the serial port register block.
// The MMU drives address, data and strobes; the serial port returns read data.
interface serial_link_port_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        read_en;
  logic        write_en;
  logic [7:0]  rdata;

  modport master (output addr, output wdata, output read_en, output write_en, input rdata);
  modport slave  (input addr, input wdata, input read_en, input write_en, output rdata);
endinterface

// File: rtl/serial_link_port.sv
// Game Boy serial port: SB (FF01) data shift register and SC (FF02) control.
// Shifts 8 bits MSB-first on sout while sampling sin, clocked either by the
// internal divider or by an external link clock, then pulses irq_serial once.
module serial_link_port #(
  parameter int CLK_DIV     = 512,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_link_port_if.slave    bus,
  output logic                 sout,
  output logic                 sclk_out,
  input  logic                 sin,
  input  logic                 sclk_in,
  output logic                 irq_serial
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_INT,
    SHIFT_EXT
  } state_t;

  state_t                 state;
  logic [7:0]             sb;
  logic                   sc_start;
  logic                   sc_int_clk;
  logic [3:0]             bit_cnt;
  logic [DIV_W-1:0]       div_cnt;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sin_sync_q;
  logic                   sclk_prev;

  logic sclk_s;
  logic sin_s;
  logic sclk_rise;
  logic sclk_fall;
  logic wr_sb;
  logic wr_sc;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sin_s     = sin_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign wr_sb     = bus.write_en && (bus.addr == 16'hFF01);
  assign wr_sc     = bus.write_en && (bus.addr == 16'hFF02);

  // Register read mux; unmapped addresses and idle bus float high.
  always_comb begin
    // NOTE: default assignment first so every path drives rdata and no latch is inferred.
    bus.rdata = 8'hFF;
    if (bus.read_en) begin
      case (bus.addr)
        16'hFF01: bus.rdata = sb;
        16'hFF02: bus.rdata = {sc_start, 6'b111111, sc_int_clk};
        default:  bus.rdata = 8'hFF;
      endcase
    end
  end

  // Input synchronisers and external clock edge history, idling high like an open link.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: presetting to 1 keeps an idle (pulled-up) link from looking like a falling edge after reset.
    if (!reset) begin
      sclk_sync  <= '1;
      sin_sync_q <= '1;
      sclk_prev  <= 1'b1;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      sin_sync_q <= {sin_sync_q[SYNC_STAGES-2:0], sin};
      sclk_prev  <= sclk_s;
    end
  end

  // Transfer control FSM with register writes, shifting and completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sb         <= 8'h00;
      sc_start   <= 1'b0;
      sc_int_clk <= 1'b0;
      sout       <= 1'b1;
      sclk_out   <= 1'b1;
      irq_serial <= 1'b0;
      bit_cnt    <= 4'd0;
      div_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees the pre-edge register values.
      irq_serial <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_sb) sb <= bus.wdata;
          if (wr_sc) begin
            sc_start   <= bus.wdata[7];
            sc_int_clk <= bus.wdata[0];
            bit_cnt    <= 4'd0;
            div_cnt    <= '0;
            if (bus.wdata[7]) state <= bus.wdata[0] ? SHIFT_INT : SHIFT_EXT;
          end
        end
        default: begin
          if (bit_cnt == 4'd8) begin
            // Completion wins over any bus write; only an SB write survives it.
            state    <= IDLE;
            sc_start <= 1'b0;
            sout     <= 1'b1;
            sclk_out <= 1'b1;
            if (wr_sb) sb <= bus.wdata;
          end else if (wr_sc && !bus.wdata[7]) begin
            // Abort keeps the partially shifted SB and raises no interrupt.
            state      <= IDLE;
            sc_start   <= 1'b0;
            sc_int_clk <= bus.wdata[0];
            sout       <= 1'b1;
            sclk_out   <= 1'b1;
          end else if (state == SHIFT_INT) begin
            div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
            if (div_cnt == '0) begin
              sclk_out <= 1'b0;
              sout     <= sb[7];
            end
            if (div_cnt == DIV_HALF) begin
              sclk_out <= 1'b1;
              sb       <= {sb[6:0], sin_s};
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) irq_serial <= 1'b1;
            end
          end else begin
            sclk_out <= 1'b1;
            if (sclk_fall) sout <= sb[7];
            if (sclk_rise) begin
              sb      <= {sb[6:0], sin_s};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) irq_serial <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_link_port.sv
// Scoreboard bench for serial_link_port with CLK_DIV=8: stimulus pushes the
// expected read data, serial bits and interrupt latencies; a negedge monitor
// pops and compares whenever the DUT presents a read, a serial clock rise or an irq.
module tb_serial_link_port;
  localparam int CLK_DIV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sout;
  logic sclk_out;
  logic irq_serial;
  logic sin_drv = 1'b1;
  logic loop_en = 1'b0;
  logic sclk_in = 1'b1;
  logic sin;

  assign sin = loop_en ? sout : sin_drv;

  serial_link_port_if bus ();

  serial_link_port #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .bus        (bus),
    .sout       (sout),
    .sclk_out   (sclk_out),
    .sin        (sin),
    .sclk_in    (sclk_in),
    .irq_serial (irq_serial)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rd_q[$];
  logic       bit_q[$];
  int         irq_q[$];

  int pos_cnt   = 0;
  int mark      = 0;
  int last_rise = -1;
  int rise_cnt  = 0;
  bit irq_seen  = 1'b0;
  logic prev_sclk = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT produced an event with nothing expected", name);
  endtask

  // Cycle counter; marks the edge that accepts a transfer-starting SC write.
  always @(posedge clk) begin
    pos_cnt++;
    if (bus.write_en && bus.addr == 16'hFF02 && bus.wdata[7]) mark = pos_cnt;
  end

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clk) begin
    if (bus.read_en) begin
      if (rd_q.size() == 0) unexpected("rdata");
      else check($sformatf("rdata@%h", bus.addr), bus.rdata, rd_q.pop_front());
    end
    if (rst_n && sclk_out && !prev_sclk) begin
      rise_cnt++;
      if (last_rise >= 0) check("sclk_period", pos_cnt - last_rise, CLK_DIV);
      last_rise = pos_cnt;
      if (bit_q.size() == 0) unexpected("sout_bit");
      else check($sformatf("sout_bit%0d", rise_cnt), sout, bit_q.pop_front());
    end
    prev_sclk = sclk_out;
    if (irq_serial) begin
      int e;
      irq_seen = 1'b1;
      if (irq_q.size() == 0) unexpected("irq_serial");
      else begin
        e = irq_q.pop_front();
        if (e >= 0) check("irq_latency", pos_cnt - mark, e);
      end
    end
  end

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus.addr     = a;
    bus.wdata    = d;
    bus.write_en = 1'b1;
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [7:0] exp);
    rd_q.push_back(exp);
    bus.addr    = a;
    bus.read_en = 1'b1;
    @(negedge clk);
    #1;
    bus.read_en = 1'b0;
  endtask

  task automatic push_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_q.push_back(b[i]);
  endtask

  task automatic wait_irq(input int limit, input string name);
    for (int i = 0; i < limit && !irq_seen; i++) begin
      @(negedge clk);
      #1;
    end
    if (!irq_seen) begin
      checks++;
      errors++;
      $display("FAIL %s: irq_serial not seen within %0d cycles, required one pulse", name, limit);
    end
  endtask

  task automatic wait_rises(input int n, input int limit, input string name);
    for (int i = 0; i < limit && rise_cnt < n; i++) begin
      @(negedge clk);
      #1;
    end
    if (rise_cnt < n) begin
      checks++;
      errors++;
      $display("FAIL %s: saw %0d sclk_out rises, required %0d", name, rise_cnt, n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.addr     = 16'h0000;
    bus.wdata    = 8'h00;
    bus.read_en  = 1'b0;
    bus.write_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset state
    bus_read(16'hFF01, 8'h00);
    bus_read(16'hFF02, 8'h7E);
    bus_read(16'hFF03, 8'hFF);
    check("reset_sout", sout, 1'b1);
    check("reset_sclk_out", sclk_out, 1'b1);
    check("reset_irq", irq_serial, 1'b0);
    bus.addr = 16'hFF01;
    #1 check("rdata_no_read_en", bus.rdata, 8'hFF);

    // 2: internal transfer of A5 with sin held high
    sin_drv = 1'b1;
    bus_write(16'hFF01, 8'hA5);
    push_bits(8'hA5);
    irq_q.push_back(8 * CLK_DIV - CLK_DIV / 2 + 1);
    last_rise = -1;
    irq_seen  = 1'b0;
    bus_write(16'hFF02, 8'h81);
    wait_irq(200, "t2_irq");
    idle(2);
    bus_read(16'hFF01, 8'hFF);
    bus_read(16'hFF02, 8'h7F);
    check("t2_bits_left", bit_q.size(), 0);

    // 3: loopback sout->sin returns the original byte, one irq pulse
    loop_en = 1'b1;
    bus_write(16'hFF01, 8'h3C);
    push_bits(8'h3C);
    irq_q.push_back(61);
    last_rise = -1;
    irq_seen  = 1'b0;
    bus_write(16'hFF02, 8'h81);
    wait_irq(200, "t3_irq");
    idle(20);
    loop_en = 1'b0;
    bus_read(16'hFF01, 8'h3C);
    bus_read(16'hFF02, 8'h7F);
    check("t3_irq_q_left", irq_q.size(), 0);

    // 4: external clock, 8 pulses with sin low, then a stalled transfer
    sin_drv = 1'b0;
    bus_write(16'hFF01, 8'hFF);
    irq_q.push_back(-1);
    irq_seen = 1'b0;
    bus_write(16'hFF02, 8'h80);
    for (int p = 0; p < 8; p++) begin
      sclk_in = 1'b0;
      idle(5);
      if (p == 3) check("t4_sclk_out_high", sclk_out, 1'b1);
      sclk_in = 1'b1;
      idle(5);
    end
    wait_irq(50, "t4_irq");
    idle(2);
    bus_read(16'hFF01, 8'h00);
    bus_read(16'hFF02, 8'h7E);
    bus_write(16'hFF02, 8'h80);
    idle(1000);
    bus_read(16'hFF02, 8'hFE);
    bus_write(16'hFF02, 8'h00);
    bus_read(16'hFF02, 8'h7E);

    // 5: SB write ignored while busy, abort after 3 bits
    sin_drv = 1'b1;
    bus_write(16'hFF01, 8'hA5);
    bit_q.push_back(1'b1);
    bit_q.push_back(1'b0);
    bit_q.push_back(1'b1);
    last_rise = -1;
    rise_cnt  = 0;
    irq_seen  = 1'b0;
    bus_write(16'hFF02, 8'h81);
    wait_rises(3, 100, "t5_rises");
    bus_write(16'hFF01, 8'h00);
    bus_write(16'hFF02, 8'h01);
    idle(40);
    bus_read(16'hFF01, 8'h2F);
    bus_read(16'hFF02, 8'h7F);
    check("t5_no_irq", irq_seen, 1'b0);
    check("t5_sclk_out_idle", sclk_out, 1'b1);

    // 7: SB write landing on the completion cycle is applied after completion
    bus_write(16'hFF01, 8'h0F);
    push_bits(8'h0F);
    irq_q.push_back(61);
    last_rise = -1;
    irq_seen  = 1'b0;
    bus_write(16'hFF02, 8'h81);
    wait_irq(200, "t7_irq");
    bus_write(16'hFF01, 8'h5A);
    idle(2);
    bus_read(16'hFF01, 8'h5A);
    bus_read(16'hFF02, 8'h7F);

    // 6: asynchronous reset mid-transfer
    bus_write(16'hFF01, 8'h80);
    bit_q.push_back(1'b1);
    last_rise = -1;
    rise_cnt  = 0;
    irq_seen  = 1'b0;
    bus_write(16'hFF02, 8'h81);
    wait_rises(1, 100, "t6_rises");
    repeat (5) @(posedge clk);
    #1;
    check("t6_sclk_low_before", sclk_out, 1'b0);
    check("t6_sout_low_before", sout, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_sout_reset", sout, 1'b1);
    check("t6_sclk_out_reset", sclk_out, 1'b1);
    check("t6_irq_reset", irq_serial, 1'b0);
    bus.addr    = 16'hFF01;
    bus.read_en = 1'b1;
    #0.5 check("t6_sb_reset", bus.rdata, 8'h00);
    bus.addr = 16'hFF02;
    #0.5 check("t6_sc_reset", bus.rdata, 8'h7E);
    bus.read_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(100);
    check("t6_no_irq", irq_seen, 1'b0);
    bus_read(16'hFF01, 8'h00);
    bus_read(16'hFF02, 8'h7E);

    check("rd_q_left", rd_q.size(), 0);
    check("bit_q_left", bit_q.size(), 0);
    check("irq_q_left", irq_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
